// File: rtl/ffstdp_sweep_ctrl.sv
// End-of-timestep FF-STDP sweep sequencer: walks every synapse address, issues SRAM
// and spike-count reads, and presents aligned operands plus write-back two cycles later.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; address counter held at 0
// SWEEP | one read issued per cycle, pre index as the inner loop
// DRAIN | two empty cycles while the last reads reach write-back
// FIN   | one-cycle DONE pulse, START ignored
module ffstdp_sweep_ctrl #(
    parameter int N_PRE          = 256,
    parameter int N_POST         = 256,
    parameter int PRE_CNT_WIDTH  = 8,
    parameter int POST_CNT_WIDTH = 7,
    localparam int PA = $clog2(N_PRE),
    localparam int QA = $clog2(N_POST),
    localparam int AW = PA + QA,
    localparam int M  = N_PRE * N_POST
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      IS_TRAIN_IN,
    input  logic                      IS_POS_IN,
    output logic                      SRAM_RE,
    output logic [AW-1:0]             SRAM_RADDR,
    output logic                      SRAM_WE,
    output logic [AW-1:0]             SRAM_WADDR,
    output logic [PA-1:0]             PRE_IDX,
    output logic [QA-1:0]             POST_IDX,
    input  logic [PRE_CNT_WIDTH-1:0]  PRE_CNT_RDATA,
    input  logic [POST_CNT_WIDTH-1:0] POST_CNT_RDATA,
    output logic [PRE_CNT_WIDTH-1:0]  PRE_SPIKE_CNT,
    output logic [POST_CNT_WIDTH-1:0] POST_SPIKE_CNT,
    output logic                      CTRL_TREF_EVENT,
    output logic                      IS_TRAIN,
    output logic                      IS_POS,
    output logic                      BUSY,
    output logic                      DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    state_t                      state;
    logic [AW-1:0]               cnt;
    logic                        drain_second;
    logic                        sram_re_q;
    logic                        v1;
    logic                        v2;
    logic [AW-1:0]               addr1;
    logic [AW-1:0]               addr2;
    logic [PRE_CNT_WIDTH-1:0]    pre_cnt_q;
    logic [POST_CNT_WIDTH-1:0]   post_cnt_q;
    logic                        is_train_q;
    logic                        is_pos_q;
    logic                        busy_q;
    logic                        done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            cnt          <= '0;
            drain_second <= 1'b0;
            sram_re_q    <= 1'b0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            addr1        <= '0;
            addr2        <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            is_train_q   <= 1'b0;
            is_pos_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            v1    <= sram_re_q;
            addr1 <= cnt;
            v2    <= v1;
            addr2 <= addr1;
            // Count memories answer one cycle after the index, so capture while v1 is live.
            pre_cnt_q  <= v1 ? PRE_CNT_RDATA : '0;
            post_cnt_q <= v1 ? POST_CNT_RDATA : '0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (START) begin
                        state      <= S_SWEEP;
                        sram_re_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        is_train_q <= IS_TRAIN_IN;
                        is_pos_q   <= IS_POS_IN;
                    end
                end
                S_SWEEP: begin
                    if (cnt == LAST_ADDR) begin
                        state        <= S_DRAIN;
                        sram_re_q    <= 1'b0;
                        cnt          <= '0;
                        drain_second <= 1'b0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_second) begin
                        state  <= S_FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_second <= 1'b1;
                    end
                end
                S_FIN: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign SRAM_RE         = sram_re_q;
    assign SRAM_RADDR      = cnt;
    assign PRE_IDX         = cnt[PA-1:0];
    assign POST_IDX        = cnt[AW-1:PA];
    assign SRAM_WE         = v2;
    assign SRAM_WADDR      = addr2;
    assign CTRL_TREF_EVENT = v2;
    assign PRE_SPIKE_CNT   = pre_cnt_q;
    assign POST_SPIKE_CNT  = post_cnt_q;
    assign IS_TRAIN        = is_train_q;
    assign IS_POS          = is_pos_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;

endmodule

// File: tb/tb_ffstdp_sweep_ctrl.sv
// Bench for ffstdp_sweep_ctrl with a 4x2 synapse array and 1-cycle count memories.
module tb_ffstdp_sweep_ctrl;

    localparam int NP = 4;
    localparam int NQ = 2;
    localparam int M  = NP * NQ;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       IS_TRAIN_IN = 1'b0;
    logic       IS_POS_IN = 1'b0;
    logic       SRAM_RE, SRAM_WE, CTRL_TREF_EVENT, IS_TRAIN, IS_POS, BUSY, DONE;
    logic [2:0] SRAM_RADDR, SRAM_WADDR;
    logic [1:0] PRE_IDX;
    logic [0:0] POST_IDX;
    logic [7:0] PRE_CNT_RDATA = '0;
    logic [6:0] POST_CNT_RDATA = '0;
    logic [7:0] PRE_SPIKE_CNT;
    logic [6:0] POST_SPIKE_CNT;

    ffstdp_sweep_ctrl #(.N_PRE(NP), .N_POST(NQ), .PRE_CNT_WIDTH(8), .POST_CNT_WIDTH(7)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IS_TRAIN_IN(IS_TRAIN_IN), .IS_POS_IN(IS_POS_IN),
        .SRAM_RE(SRAM_RE), .SRAM_RADDR(SRAM_RADDR), .SRAM_WE(SRAM_WE), .SRAM_WADDR(SRAM_WADDR),
        .PRE_IDX(PRE_IDX), .POST_IDX(POST_IDX),
        .PRE_CNT_RDATA(PRE_CNT_RDATA), .POST_CNT_RDATA(POST_CNT_RDATA),
        .PRE_SPIKE_CNT(PRE_SPIKE_CNT), .POST_SPIKE_CNT(POST_SPIKE_CNT),
        .CTRL_TREF_EVENT(CTRL_TREF_EVENT), .IS_TRAIN(IS_TRAIN), .IS_POS(IS_POS),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    logic [7:0] pre_mem [NP];
    logic [6:0] post_mem [NQ];

    always @(posedge CLK) begin
        PRE_CNT_RDATA  <= pre_mem[PRE_IDX];
        POST_CNT_RDATA <= post_mem[POST_IDX];
    end

    typedef struct {
        logic [2:0] addr;
        logic [7:0] pre;
        logic [6:0] post;
        logic       tr;
        logic       ps;
    } wr_t;

    typedef struct {
        bit tr;
        bit ps;
        bit toggle;
        bit extra_start;
        int pre_base;
        int post_base;
    } vec_t;

    wr_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-back scoreboard: every SRAM_WE must match the next expected record.
    always @(negedge CLK) begin
        wr_t r;
        if (DONE) done_cnt++;
        if (SRAM_WE) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(SRAM_WADDR), 32'hFFFF);
            end else begin
                r = sb.pop_front();
                chk("wb_addr", 32'(SRAM_WADDR), 32'(r.addr));
                chk("wb_pre_cnt", 32'(PRE_SPIKE_CNT), 32'(r.pre));
                chk("wb_post_cnt", 32'(POST_SPIKE_CNT), 32'(r.post));
                chk("wb_tref", 32'(CTRL_TREF_EVENT), 32'd1);
                chk("wb_is_train", 32'(IS_TRAIN), 32'(r.tr));
                chk("wb_is_pos", 32'(IS_POS), 32'(r.ps));
            end
        end
        if (RST) sb.delete();
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_mem(input int pb, input int qb);
        for (int i = 0; i < NP; i++) pre_mem[i] = 8'(pb + i);
        for (int i = 0; i < NQ; i++) post_mem[i] = 7'(qb + i);
    endtask

    task automatic push_sweep(input bit tr, input bit ps);
        wr_t r;
        for (int a = 0; a < M; a++) begin
            r.addr = 3'(a);
            r.pre  = pre_mem[a % NP];
            r.post = post_mem[a / NP];
            r.tr   = tr;
            r.ps   = ps;
            sb.push_back(r);
        end
    endtask

    // Timing model relative to the accept cycle (rel 0).
    task automatic check_cycle(input int rel, input bit tr, input bit ps);
        bit exp_re, exp_we;
        exp_re = (rel >= 1) && (rel <= M);
        exp_we = (rel >= 3) && (rel <= M + 2);
        chk($sformatf("re@%0d", rel), 32'(SRAM_RE), 32'(exp_re));
        if (exp_re) begin
            chk($sformatf("raddr@%0d", rel), 32'(SRAM_RADDR), 32'(rel - 1));
            chk($sformatf("pre_idx@%0d", rel), 32'(PRE_IDX), 32'((rel - 1) % NP));
            chk($sformatf("post_idx@%0d", rel), 32'(POST_IDX), 32'((rel - 1) / NP));
        end
        chk($sformatf("we@%0d", rel), 32'(SRAM_WE), 32'(exp_we));
        chk($sformatf("tref@%0d", rel), 32'(CTRL_TREF_EVENT), 32'(exp_we));
        if (exp_we) chk($sformatf("waddr@%0d", rel), 32'(SRAM_WADDR), 32'(rel - 3));
        chk($sformatf("busy@%0d", rel), 32'(BUSY), 32'((rel >= 1) && (rel <= M + 2)));
        chk($sformatf("done@%0d", rel), 32'(DONE), 32'(rel == M + 3));
        chk($sformatf("is_train@%0d", rel), 32'(IS_TRAIN), 32'(tr));
        chk($sformatf("is_pos@%0d", rel), 32'(IS_POS), 32'(ps));
    endtask

    vec_t vecs [3];

    initial begin
        int wr_base, done_base;

        vecs[0] = '{tr: 1'b1, ps: 1'b0, toggle: 1'b1, extra_start: 1'b1, pre_base: 5,   post_base: 1};
        vecs[1] = '{tr: 1'b0, ps: 1'b1, toggle: 1'b0, extra_start: 1'b0, pre_base: 20,  post_base: 9};
        vecs[2] = '{tr: 1'b1, ps: 1'b1, toggle: 1'b1, extra_start: 1'b1, pre_base: 100, post_base: 60};
        load_mem(5, 1);

        // Reset held 3 cycles with START and flags high: nothing may start.
        RST = 1'b1;
        START = 1'b1;
        IS_TRAIN_IN = 1'b1;
        IS_POS_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge CLK);
            chk("rst_re", 32'(SRAM_RE), 32'd0);
            chk("rst_we", 32'(SRAM_WE), 32'd0);
            chk("rst_busy", 32'(BUSY), 32'd0);
            chk("rst_done", 32'(DONE), 32'd0);
            chk("rst_raddr", 32'(SRAM_RADDR), 32'd0);
            chk("rst_flags", 32'({IS_TRAIN, IS_POS}), 32'd0);
            chk("rst_cnts", 32'({PRE_SPIKE_CNT, POST_SPIKE_CNT}), 32'd0);
        end
        next_cycle();
        RST = 1'b0;
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge CLK);
            chk("post_rst_busy", 32'(BUSY), 32'd0);
            chk("post_rst_re", 32'(SRAM_RE), 32'd0);
        end

        // Table-driven full sweeps.
        for (int v = 0; v < 3; v++) begin
            load_mem(vecs[v].pre_base, vecs[v].post_base);
            wr_base = wr_cnt;
            done_base = done_cnt;
            next_cycle();
            START = 1'b1;
            IS_TRAIN_IN = vecs[v].tr;
            IS_POS_IN = vecs[v].ps;
            push_sweep(vecs[v].tr, vecs[v].ps);
            @(negedge CLK);
            for (int rel = 1; rel <= M + 4; rel++) begin
                next_cycle();
                START = vecs[v].extra_start && (rel == 4 || rel == M + 3);
                if (vecs[v].toggle && rel == 5) begin
                    IS_TRAIN_IN = ~IS_TRAIN_IN;
                    IS_POS_IN = ~IS_POS_IN;
                end
                @(negedge CLK);
                check_cycle(rel, vecs[v].tr, vecs[v].ps);
                if (v == 0 && rel == 9) begin
                    chk("addr6_pre_cnt", 32'(PRE_SPIKE_CNT), 32'd7);
                    chk("addr6_post_cnt", 32'(POST_SPIKE_CNT), 32'd2);
                end
            end
            START = 1'b0;
            chk($sformatf("writes_v%0d", v), 32'(wr_cnt - wr_base), 32'(M));
            chk($sformatf("dones_v%0d", v), 32'(done_cnt - done_base), 32'd1);
            chk($sformatf("sb_empty_v%0d", v), 32'(sb.size()), 32'd0);
        end

        // Reset in cycle 5 of a sweep, then a clean restart from address 0.
        load_mem(5, 1);
        wr_base = wr_cnt;
        next_cycle();
        START = 1'b1;
        IS_TRAIN_IN = 1'b1;
        IS_POS_IN = 1'b0;
        push_sweep(1'b1, 1'b0);
        @(negedge CLK);
        for (int rel = 1; rel <= 5; rel++) begin
            next_cycle();
            START = 1'b0;
            RST = (rel == 5);
            @(negedge CLK);
            check_cycle(rel, 1'b1, 1'b0);
        end
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_we", 32'(SRAM_WE), 32'd0);
        chk("midrst_re", 32'(SRAM_RE), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_flags", 32'({IS_TRAIN, IS_POS}), 32'd0);
        chk("midrst_writes", 32'(wr_cnt - wr_base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge CLK);
            chk("midrst_idle_we", 32'(SRAM_WE), 32'd0);
        end
        chk("midrst_sb_flushed", 32'(sb.size()), 32'd0);

        wr_base = wr_cnt;
        done_base = done_cnt;
        next_cycle();
        START = 1'b1;
        IS_TRAIN_IN = 1'b0;
        IS_POS_IN = 1'b0;
        push_sweep(1'b0, 1'b0);
        @(negedge CLK);
        for (int rel = 1; rel <= M + 4; rel++) begin
            next_cycle();
            START = 1'b0;
            @(negedge CLK);
            check_cycle(rel, 1'b0, 1'b0);
        end
        chk("restart_writes", 32'(wr_cnt - wr_base), 32'(M));
        chk("restart_dones", 32'(done_cnt - done_base), 32'd1);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ffstdp_sweep_ctrl.md
# ffstdp_sweep_ctrl

Sequencer that drives the FF-STDP synaptic update at the end of a timestep. On `START` it walks every synapse address once. For each synapse it issues a read of the weight/gradient SRAM and of the pre/post spike-count memories. Two cycles later it presents the aligned spike counts, `CTRL_TREF_EVENT` and the session flags to the `ffstdp_update` datapath, and writes the result back to the same SRAM address. It sits directly upstream of `ffstdp_update`, between the core scheduler and the synaptic SRAM.

## Interface
Parameters:
- `N_PRE`, 256: number of presynaptic neurons; must be a power of 2 and ≥ 2.
- `N_POST`, 256: number of postsynaptic neurons; must be a power of 2 and ≥ 2.
- `PRE_CNT_WIDTH`, 8: width of a pre spike count.
- `POST_CNT_WIDTH`, 7: width of a post spike count.
- Derived: `PA = $clog2(N_PRE)`, `QA = $clog2(N_POST)`, `AW = PA+QA`, `M = N_PRE*N_POST`.

Ports:
- `CLK` in 1: clock. All logic is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `START` in 1: single-cycle request to begin a sweep.
- `IS_TRAIN_IN` in 1: session flag, sampled only when `START` is accepted.
- `IS_POS_IN` in 1: session flag, sampled only when `START` is accepted.
- `SRAM_RE` out 1: synaptic SRAM read enable.
- `SRAM_RADDR` out AW: read address, `{post_idx, pre_idx}`.
- `SRAM_WE` out 1: synaptic SRAM write enable.
- `SRAM_WADDR` out AW: write-back address.
- `PRE_IDX` out PA: address into the pre-count memory.
- `POST_IDX` out QA: address into the post-count memory.
- `PRE_CNT_RDATA` in PRE_CNT_WIDTH: pre-count memory data, valid 1 cycle after `PRE_IDX`.
- `POST_CNT_RDATA` in POST_CNT_WIDTH: post-count memory data, valid 1 cycle after `POST_IDX`.
- `PRE_SPIKE_CNT` out PRE_CNT_WIDTH: to `ffstdp_update`.
- `POST_SPIKE_CNT` out POST_CNT_WIDTH: to `ffstdp_update`.
- `CTRL_TREF_EVENT` out 1: to `ffstdp_update`.
- `IS_TRAIN` out 1: latched session flag, to `ffstdp_update`.
- `IS_POS` out 1: latched session flag, to `ffstdp_update`.
- `BUSY` out 1: sweep in progress.
- `DONE` out 1: single-cycle pulse at sweep end.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, FIN.
- IDLE:
  - `START`=1 → SWEEP.
  - Clear the address counter to 0.
  - Latch `IS_TRAIN_IN` into `IS_TRAIN` and `IS_POS_IN` into `IS_POS`.
- SWEEP:
  - Each cycle, assert `SRAM_RE` with `SRAM_RADDR` = counter.
  - Drive `PRE_IDX` = counter[PA-1:0] and `POST_IDX` = counter[AW-1:PA].
  - Increment the counter; pre index is the inner loop.
  - After issuing address M-1 → DRAIN.
- DRAIN: issue nothing. Stay 2 cycles to empty the pipeline, then → FIN.
- FIN: assert `DONE` for exactly one cycle, then → IDLE.
- Issue pipeline: 2-stage valid/address shift register, v0→v1→v2 with matching address stages.
- Count alignment: `PRE_CNT_RDATA`/`POST_CNT_RDATA` are registered once, so `PRE_SPIKE_CNT`/`POST_SPIKE_CNT` are valid at issue+2.
- Write-back stage (issue+2):
  - `SRAM_WE` = v2.
  - `SRAM_WADDR` = addr2.
  - `CTRL_TREF_EVENT` = v2.
- Read and write addresses always differ by 2 entries, so there is no same-address read/write conflict. Requires a dual-port SRAM.
- `BUSY` = (state ≠ IDLE) && (state ≠ FIN).
- `START` is ignored while not in IDLE; this includes FIN.
- `IS_TRAIN`/`IS_POS` are held constant from the accept cycle until the next accepted `START`.
- Counter is AW bits. Terminal detection is by count == M-1, not by wrap.
- RST at any point, including mid-sweep:
  - Next state IDLE.
  - Counter, pipeline valids and all outputs go to 0.
  - No further `SRAM_WE`; the partially swept array is left as-is.

## Timing
- Reset values: all outputs 0.
- `START` sampled in cycle 0 → first `SRAM_RE` (address 0) in cycle 1.
- Address k is read in cycle k+1 and written in cycle k+3.
- Last read in cycle M; last write in cycle M+2.
- `DONE`=1 in cycle M+3.
- `BUSY` is high in cycles 1..M+2.
- Earliest next accepted `START` is cycle M+4.
- Sweep length: M+3 cycles from accept to `DONE`.
- Outputs are registered, except that `SRAM_WE`, `SRAM_WADDR` and `CTRL_TREF_EVENT` come directly from stage-2 registers.

## Test plan
- Bench setup: `N_PRE`=4, `N_POST`=2 (M=8), with a behavioural 1-cycle-latency SRAM and count memories.
- Reset: hold `RST` 3 cycles → all outputs 0, state IDLE. `START` asserted together with `RST` → no sweep.
- Full sweep: `START` in cycle 0 →
  - `SRAM_RADDR` 0..7 in cycles 1..8.
  - `SRAM_WADDR` 0..7 with `SRAM_WE` in cycles 3..10.
  - `DONE` only in cycle 11.
  - `BUSY` high in cycles 1..10.
- Count alignment: pre-count memory = {5,6,7,8}, post-count memory = {1,2} → at the write of address 6, `PRE_SPIKE_CNT`=7 and `POST_SPIKE_CNT`=2.
- Flag latch: `START` with `IS_TRAIN_IN`=1 and `IS_POS_IN`=0, then toggle both inputs mid-sweep → `IS_TRAIN`=1 and `IS_POS`=0 for the whole sweep.
- Ignored start: pulse `START` in cycles 4 and 11 → exactly one sweep of 8 writes, `DONE` in cycle 11 only.
- Reset mid-sweep: `RST` in cycle 5 → cycle 6 has no `SRAM_WE`. Later `START` restarts at address 0, with full write count 8.
